// File: rtl/multi_clk_divider_if.sv
// Configuration write port for multi_clk_divider: one strobe-qualified write
// per cycle, with a registered reject flag returned on the following cycle.
interface multi_clk_divider_if #(
    parameter int CNT_W = 16,
    parameter int CH_W  = 2
);
    // wr_en is a one-cycle strobe with no ready; the write is either taken on
    // that edge or rejected, and wr_err reports a reject one cycle later.
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_div;
    logic [CNT_W-1:0] wr_high;
    logic             wr_err;

    modport master (output wr_en, output wr_ch, output wr_div, output wr_high, input wr_err);
    modport slave  (input wr_en, input wr_ch, input wr_div, input wr_high, output wr_err);
endinterface

// File: rtl/multi_clk_divider.sv
// Multi-channel programmable clock-enable divider with rise/fall ticks,
// shadowed glitch-free reconfiguration and a global phase sync.
module multi_clk_divider #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 16,
    parameter int CH_W         = 2,
    parameter int DEFAULT_DIV  = 24,
    parameter int DEFAULT_HIGH = 12
) (
    input  logic              clk,
    input  logic              reset,
    multi_clk_divider_if.slave cfg,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] rise_tick,
    output logic [NUM_CH-1:0] fall_tick,
    output logic [NUM_CH-1:0] pend
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEFAULT_HIGH);
    localparam logic [CNT_W-1:0] CNT_RST  = DIV_RST - CNT_W'(1);

    logic [CNT_W-1:0] divA   [NUM_CH];
    logic [CNT_W-1:0] highA  [NUM_CH];
    logic [CNT_W-1:0] divS   [NUM_CH];
    logic [CNT_W-1:0] highS  [NUM_CH];
    logic [CNT_W-1:0] cnt    [NUM_CH];
    logic [CNT_W-1:0] divAN  [NUM_CH];
    logic [CNT_W-1:0] highAN [NUM_CH];
    logic [CNT_W-1:0] divSN  [NUM_CH];
    logic [CNT_W-1:0] highSN [NUM_CH];
    logic [CNT_W-1:0] cntN   [NUM_CH];
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] wrHit;
    logic [NUM_CH-1:0] pendN;
    logic [NUM_CH-1:0] outN;
    logic              wrOk;

    always_comb begin
        wrOk = cfg.wr_en && (int'(cfg.wr_ch) < NUM_CH) &&
               (cfg.wr_div >= CNT_W'(2)) && (cfg.wr_high <= cfg.wr_div);
    end

    always_comb begin
        divAN  = divA;
        highAN = highA;
        divSN  = divS;
        highSN = highS;
        cntN   = cnt;
        pendN  = pend;
        outN   = '0;
        wrap   = '0;
        wrHit  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wrHit[i] = wrOk && (int'(cfg.wr_ch) == i);
            wrap[i]  = sync || (cnt[i] == divA[i] - CNT_W'(1));
            // Shadow values move to active only at a period boundary or while idle,
            // so the waveform never sees a half-old, half-new period.
            if ((!ch_en[i] || wrap[i]) && pend[i]) begin
                divAN[i]  = divS[i];
                highAN[i] = highS[i];
                pendN[i]  = 1'b0;
            end
            if (!ch_en[i]) begin
                cntN[i] = divAN[i] - CNT_W'(1);
                outN[i] = 1'b0;
            end else if (wrap[i]) begin
                cntN[i] = '0;
                outN[i] = (highAN[i] != '0);
            end else begin
                cntN[i] = cnt[i] + CNT_W'(1);
                outN[i] = (cntN[i] < highA[i]);
            end
            // A write landing on the apply edge only arms the next boundary.
            if (wrHit[i]) begin
                divSN[i]  = cfg.wr_div;
                highSN[i] = cfg.wr_high;
                pendN[i]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                divA[i]  <= DIV_RST;
                highA[i] <= HIGH_RST;
                divS[i]  <= DIV_RST;
                highS[i] <= HIGH_RST;
                cnt[i]   <= CNT_RST;
            end
            div_out    <= '0;
            rise_tick  <= '0;
            fall_tick  <= '0;
            pend       <= '0;
            cfg.wr_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                divA[i]  <= divAN[i];
                highA[i] <= highAN[i];
                divS[i]  <= divSN[i];
                highS[i] <= highSN[i];
                cnt[i]   <= cntN[i];
            end
            div_out    <= outN;
            rise_tick  <= outN & ~div_out;
            fall_tick  <= ~outN & div_out;
            pend       <= pendN;
            cfg.wr_err <= cfg.wr_en && !wrOk;
        end
    end

endmodule
